cpu_quad_clkgen: RTL and testbench

Generates the 6809-style quadrature CPU clock pair (E, Q) and single-cycle edge strobes from the 48M master clock. It sits directly upstream of cus41 and drives its CLK_0/CLK_1 inputs. Its phase is locked to the CLK_S2H output of the cus27 clock divider. It also provides MRDY-style E-high cycle stretching with a bounded timeout.

---
 rtl/cpu_quad_clkgen_pkg.sv | 20 ++
 rtl/cpu_quad_clkgen_sync_edge_detect.sv | 32 +++
 rtl/cpu_quad_clkgen.sv | 164 ++++++++++++++++
 tb/tb_cpu_quad_clkgen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_quad_clkgen_pkg.sv
// -----------------------------------------------------------------------------
// cpu_quad_clkgen_pkg
// Shared definitions for the 6809-style quadrature clock generator:
//   - FSM state encoding
//   - helper for the quarter points of an E period of DIV master clocks
// -----------------------------------------------------------------------------
package cpu_quad_clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RUN       = 2'd1,
        STRETCH   = 2'd2
    } clkgen_state_e;

    // Phase value at quarter point k (0..3) of a DIV-long E period.
    function automatic int unsigned phase_pt(input int unsigned div, input int unsigned k);
        return (div / 4) * k;
    endfunction

endpackage

// File: rtl/cpu_quad_clkgen_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// cpu_quad_clkgen_sync_edge_detect
// Registers a reference signal that is already synchronous to i_clk and flags
// its rising edge. o_rise is combinational: high in the cycle where i_d is 1
// and the previous sampled value was 0.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (clears the history bit)
//   i_d      reference input
//   o_rise   rising-edge flag
// -----------------------------------------------------------------------------
module cpu_quad_clkgen_sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d <= 1'b0;
        end else begin
            r_d <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/cpu_quad_clkgen.sv
// -----------------------------------------------------------------------------
// cpu_quad_clkgen
// Generates the quadrature CPU clock pair (E, Q) plus one-cycle edge strobes
// from the master clock, phase-locked to SYNC_IN, with E-high stretching on
// nMRDY bounded by STRETCH_MAX extra cycles.
//
// Ports:
//   CLK_48M     master clock
//   rst         asynchronous active-low reset
//   SYNC_IN     phase reference, synchronous to CLK_48M
//   nMRDY       active-low stretch request
//   E, Q        CPU clocks (Q leads E by DIV/4)
//   E_RISE/E_FALL/Q_RISE/Q_FALL  one-cycle strobes on the first cycle of a level
//   RUNNING     1 in RUN or STRETCH
//   STRETCH_TO  one-cycle pulse when a stretch is cut off by the timeout
//
// State      | meaning
// -----------+-----------------------------------------------------------------
// WAIT_SYNC  | idle, p held at 0, waiting for SYNC_IN rise (or none if !USE_SYNC)
// RUN        | p advances every cycle, wrapping DIV-1 -> 0
// STRETCH    | p held at DIV-1 (E high, Q low) while nMRDY low, bounded
// -----------------------------------------------------------------------------
module cpu_quad_clkgen
    import cpu_quad_clkgen_pkg::*;
#(
    parameter int unsigned DIV         = 32,
    parameter bit          USE_SYNC    = 1'b1,
    parameter int unsigned STRETCH_MAX = 15
) (
    input  logic CLK_48M,
    input  logic rst,
    input  logic SYNC_IN,
    input  logic nMRDY,
    output logic E,
    output logic Q,
    output logic E_RISE,
    output logic E_FALL,
    output logic Q_RISE,
    output logic Q_FALL,
    output logic RUNNING,
    output logic STRETCH_TO
);

    localparam int unsigned PW = $clog2(DIV);
    localparam int unsigned CW = (STRETCH_MAX > 0) ? $clog2(STRETCH_MAX + 1) : 1;
    localparam bit STRETCH_EN = (STRETCH_MAX != 0);

    localparam logic [PW-1:0] P_QTR  = PW'(phase_pt(DIV, 1));
    localparam logic [PW-1:0] P_HALF = PW'(phase_pt(DIV, 2));
    localparam logic [PW-1:0] P_3QTR = PW'(phase_pt(DIV, 3));
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    // Counter holds 0 in the first stretch cycle, so the last allowed stretch
    // cycle is the one where it reads STRETCH_MAX-1.
    localparam logic [CW-1:0] C_MAX  = CW'(STRETCH_MAX);
    localparam logic [CW-1:0] C_LAST = CW'((STRETCH_MAX == 0) ? 0 : STRETCH_MAX - 1);

    clkgen_state_e r_state, w_state_nxt;
    logic [PW-1:0] r_p, w_p_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_sync_rise;
    logic          w_timeout;
    logic          w_adv;

    logic r_e, r_q, r_e_rise, r_e_fall, r_q_rise, r_q_fall, r_running, r_stretch_to;

    cpu_quad_clkgen_sync_edge_detect u_sync (
        .i_clk   (CLK_48M),
        .i_rst_n (rst),
        .i_d     (SYNC_IN),
        .o_rise  (w_sync_rise)
    );

    always_ff @(posedge CLK_48M or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_SYNC;
            r_p     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                w_p_nxt = '0;
                if (!USE_SYNC || w_sync_rise) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_p == P_LAST) begin
                    if (!nMRDY && STRETCH_EN) begin
                        w_state_nxt = STRETCH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_p_nxt = '0;
                    end
                end else begin
                    w_p_nxt = r_p + 1'b1;
                end
            end
            STRETCH: begin
                w_cnt_nxt = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
                // Timeout wins over a release arriving in the same cycle.
                if (r_cnt == C_LAST) begin
                    w_timeout   = 1'b1;
                    w_p_nxt     = '0;
                    w_state_nxt = RUN;
                end else if (nMRDY) begin
                    w_p_nxt     = '0;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = WAIT_SYNC;
                w_p_nxt     = '0;
            end
        endcase
    end

    // Strobes fire only when p actually moves; WAIT_SYNC -> RUN keeps p at 0
    // and therefore produces no E_FALL.
    assign w_adv = (r_state != WAIT_SYNC) && (w_p_nxt != r_p);

    always_ff @(posedge CLK_48M or negedge rst) begin
        if (!rst) begin
            r_e          <= 1'b0;
            r_q          <= 1'b0;
            r_e_rise     <= 1'b0;
            r_e_fall     <= 1'b0;
            r_q_rise     <= 1'b0;
            r_q_fall     <= 1'b0;
            r_running    <= 1'b0;
            r_stretch_to <= 1'b0;
        end else begin
            r_e          <= (w_p_nxt >= P_HALF);
            r_q          <= (w_p_nxt >= P_QTR) && (w_p_nxt < P_3QTR);
            r_e_rise     <= w_adv && (w_p_nxt == P_HALF);
            r_e_fall     <= w_adv && (w_p_nxt == '0);
            r_q_rise     <= w_adv && (w_p_nxt == P_QTR);
            r_q_fall     <= w_adv && (w_p_nxt == P_3QTR);
            r_running    <= (w_state_nxt != WAIT_SYNC);
            r_stretch_to <= w_timeout;
        end
    end

    assign E          = r_e;
    assign Q          = r_q;
    assign E_RISE     = r_e_rise;
    assign E_FALL     = r_e_fall;
    assign Q_RISE     = r_q_rise;
    assign Q_FALL     = r_q_fall;
    assign RUNNING    = r_running;
    assign STRETCH_TO = r_stretch_to;

endmodule

// File: tb/tb_cpu_quad_clkgen.sv
// -----------------------------------------------------------------------------
// tb_cpu_quad_clkgen
// Four instances share clock, reset and SYNC_IN:
//   0: USE_SYNC=1, STRETCH_MAX=15   1: USE_SYNC=0, STRETCH_MAX=15
//   2: USE_SYNC=1, STRETCH_MAX=4    3: USE_SYNC=1, STRETCH_MAX=0
// A behavioural model pushes the expected output vector of every instance
// into a queue when the inputs for a cycle are driven; the vectors are popped
// and compared after the clock edge. Event timestamps and E-high lengths are
// also checked against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_cpu_quad_clkgen;

    localparam int DIVM = 32;
    localparam int NI   = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          sync_in = 1'b0;
    logic [NI-1:0] nmrdy   = '1;
    logic [NI-1:0] w_e, w_q, w_er, w_ef, w_qr, w_qf, w_run, w_to;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cpu_quad_clkgen #(
            .DIV         (DIVM),
            .USE_SYNC    (g != 1),
            .STRETCH_MAX (g == 2 ? 4 : (g == 3 ? 0 : 15))
        ) u_dut (
            .CLK_48M    (clk),
            .rst        (rst_n),
            .SYNC_IN    (sync_in),
            .nMRDY      (nmrdy[g]),
            .E          (w_e[g]),
            .Q          (w_q[g]),
            .E_RISE     (w_er[g]),
            .E_FALL     (w_ef[g]),
            .Q_RISE     (w_qr[g]),
            .Q_FALL     (w_qf[g]),
            .RUNNING    (w_run[g]),
            .STRETCH_TO (w_to[g])
        );
    end

    int n_cmp;
    int n_bad;
    int cyc;

    // model state per instance
    int   m_st [NI];
    int   m_p  [NI];
    int   m_n  [NI];
    logic m_sd [NI];
    logic [7:0] sb_q [$];

    // monitors
    int hi_len [NI];
    int hl     [NI][8];
    int hl_n   [NI];
    int to_cnt [NI];
    int ef_cnt [NI];
    int t_run [NI], t_qr [NI], t_er [NI], t_qf [NI], t_ef [NI], t_to [NI];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int usync_of(input int i);
        return (i != 1) ? 1 : 0;
    endfunction

    function automatic int smax_of(input int i);
        return (i == 2) ? 4 : ((i == 3) ? 0 : 15);
    endfunction

    function automatic logic [7:0] dut_vec(input int i);
        return {w_e[i], w_q[i], w_er[i], w_ef[i], w_qr[i], w_qf[i], w_run[i], w_to[i]};
    endfunction

    task automatic model_reset(input int i);
        m_st[i] = 0;
        m_p[i]  = 0;
        m_n[i]  = 0;
        m_sd[i] = 1'b0;
    endtask

    // vector order: E Q E_RISE E_FALL Q_RISE Q_FALL RUNNING STRETCH_TO
    task automatic model_step(input int i, input logic s, input logic nm, output logic [7:0] ev);
        int p0;
        bit to;
        ev = '0;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        p0 = m_p[i];
        to = 1'b0;
        case (m_st[i])
            0: begin
                if (usync_of(i) == 0 || (s && !m_sd[i])) m_st[i] = 1;
            end
            1: begin
                if (m_p[i] < DIVM - 1) begin
                    m_p[i] = m_p[i] + 1;
                end else if (!nm && smax_of(i) > 0) begin
                    m_st[i] = 2;
                    m_n[i]  = 0;
                end else begin
                    m_p[i] = 0;
                end
            end
            default: begin
                m_n[i] = m_n[i] + 1;  // stretch cycles spent so far
                if (m_n[i] >= smax_of(i)) begin
                    to = 1'b1;
                    m_p[i] = 0;
                    m_st[i] = 1;
                end else if (nm) begin
                    m_p[i] = 0;
                    m_st[i] = 1;
                end
            end
        endcase
        m_sd[i] = s;
        ev[7] = (m_p[i] >= DIVM / 2);
        ev[6] = (m_p[i] >= DIVM / 4) && (m_p[i] < 3 * DIVM / 4);
        ev[5] = (m_p[i] != p0) && (m_p[i] == DIVM / 2);
        ev[4] = (m_p[i] != p0) && (m_p[i] == 0);
        ev[3] = (m_p[i] != p0) && (m_p[i] == DIVM / 4);
        ev[2] = (m_p[i] != p0) && (m_p[i] == 3 * DIVM / 4);
        ev[1] = (m_st[i] != 0);
        ev[0] = to;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < NI; i++) begin
            hi_len[i] = 0; hl_n[i] = 0; to_cnt[i] = 0; ef_cnt[i] = 0;
            t_run[i] = -1; t_qr[i] = -1; t_er[i] = -1; t_qf[i] = -1; t_ef[i] = -1; t_to[i] = -1;
            for (int k = 0; k < 8; k++) hl[i][k] = 0;
        end
    endtask

    task automatic monitor(input int i);
        if (w_e[i]) begin
            hi_len[i]++;
        end else if (hi_len[i] != 0) begin
            if (hl_n[i] < 8) begin
                hl[i][hl_n[i]] = hi_len[i];
                hl_n[i]++;
            end
            hi_len[i] = 0;
        end
        if (w_to[i]) to_cnt[i]++;
        if (w_ef[i]) ef_cnt[i]++;
        if (w_run[i] && t_run[i] < 0) t_run[i] = cyc;
        if (w_qr[i]  && t_qr[i]  < 0) t_qr[i]  = cyc;
        if (w_er[i]  && t_er[i]  < 0) t_er[i]  = cyc;
        if (w_qf[i]  && t_qf[i]  < 0) t_qf[i]  = cyc;
        if (w_ef[i]  && t_ef[i]  < 0) t_ef[i]  = cyc;
        if (w_to[i]  && t_to[i]  < 0) t_to[i]  = cyc;
    endtask

    // Inputs for the current cycle are already driven; predict, clock, compare.
    task automatic step();
        logic [7:0] ev;
        for (int i = 0; i < NI; i++) begin
            model_step(i, sync_in, nmrdy[i], ev);
            sb_q.push_back(ev);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (sb_q.size() == 0) begin
                chk($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
            end else begin
                chk($sformatf("vec%0d", i), dut_vec(i), sb_q.pop_front());
            end
            monitor(i);
        end
    endtask

    int base;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        for (int i = 0; i < NI; i++) model_reset(i);
        clear_mon();

        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("reset_out%0d", i), dut_vec(i), 8'h00);

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lock, nominal periods, stretch, timeout, SYNC_IN toggling
        while (cyc < 146) begin
            sync_in  = (cyc >= 10) && (((cyc - 10) % 8) < 4);
            nmrdy[0] = !((cyc >= 74 && cyc <= 78) || cyc >= 143);
            nmrdy[1] = (cyc < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
            nmrdy[2] = 1'b0;
            nmrdy[3] = 1'b0;
            step();
        end

        chk("t1_run",   t_run[0], 11);
        chk("t1_qrise", t_qr[0],  19);
        chk("t1_erise", t_er[0],  27);
        chk("t1_qfall", t_qf[0],  35);
        chk("t1_efall", t_ef[0],  43);
        chk("t1_qlead", t_er[0] - t_qr[0], 8);
        chk("t2_run",   t_run[1], 1);
        chk("t2_qrise", t_qr[1],  9);
        chk("t3_hi0",   hl[0][0], 16);
        chk("t3_hi1",   hl[0][1], 21);
        chk("t3_hi2",   hl[0][2], 16);
        chk("t3_to",    to_cnt[0], 0);
        chk("t3_efall_cnt", ef_cnt[0], 3);
        chk("t4_hi0",   hl[2][0], 20);
        chk("t4_hi1",   hl[2][1], 20);
        chk("t4_to_first", t_to[2], 47);
        chk("t4_ef_first", t_ef[2], 47);
        chk("t4_to_cnt", to_cnt[2], 3);
        chk("t6_hi0",   hl[3][0], 16);
        chk("t6_hi1",   hl[3][1], 16);
        chk("t6_to",    to_cnt[3], 0);
        chk("t6_efall_cnt", ef_cnt[3], 4);

        // instance 0 is mid-stretch here; pull reset between clock edges
        chk("t5_in_stretch", {w_run[0], w_e[0], w_q[0]}, 3'b110);
        #2;
        rst_n   = 1'b0;
        sync_in = 1'b0;
        nmrdy   = '1;
        #1;
        for (int i = 0; i < NI; i++) begin
            model_reset(i);
            chk($sformatf("t5_async_out%0d", i), dut_vec(i), 8'h00);
        end
        clear_mon();
        for (int k = 0; k < 3; k++) step();

        rst_n = 1'b1;
        base  = cyc;
        while (cyc < base + 70) begin
            sync_in  = ((cyc - base) >= 6) && ((cyc - base) < 9);
            nmrdy[0] = 1'b1;
            nmrdy[1] = ($urandom_range(0, 2) != 0);
            nmrdy[2] = 1'b0;
            nmrdy[3] = 1'b0;
            step();
        end

        chk("t5_relock",   t_run[0], base + 7);
        chk("t5_b_restart", t_run[1], base + 1);
        chk("t5_c_relock", t_run[2], base + 7);
        chk("t5_qrise",    t_qr[0],  base + 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
